// File: rtl/cp0_timer_unit.sv
// cp0_timer_unit: coprocessor-0 exception control (SR/Cause/EPC/BadVAddr)
// with a prescaled Count/Compare timer that drives the top interrupt-pending bit.
module cp0_timer_unit #(
  parameter int          NUM_HWINT = 5,
  parameter int          COUNT_DIV = 2,
  parameter logic [31:0] PRID      = 32'h0000_7C07
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           CP0_Addr,
  input  logic [31:0]          CP0_in,
  input  logic [31:0]          VPC,
  input  logic                 BD_in,
  input  logic [4:0]           ExcCode_in,
  input  logic [31:0]          BadVAddr_in,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXL_clr,
  output logic [31:0]          CP0_out,
  output logic [31:0]          EPC_out,
  output logic                 Req,
  output logic                 Timer_irq
);

  // Timer interrupt sits directly above the external lines in IP/IM.
  localparam int TB = 10 + NUM_HWINT;
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  // Architectural state
  logic [31:0]          r_badvaddr;
  logic [31:0]          r_count;
  logic [31:0]          r_compare;
  logic [PW-1:0]        r_presc;
  logic                 r_ti;
  logic [NUM_HWINT:0]   r_im;
  logic                 r_exl;
  logic                 r_ie;
  logic [31:0]          r_epc;
  logic                 r_bd;
  logic [4:0]           r_exccode;
  logic [NUM_HWINT-1:0] r_ip_hw;

  // Request and write-qualification terms
  logic [NUM_HWINT:0] w_pend;
  logic               w_req_int;
  logic               w_req_exc;
  logic               w_req;
  logic               w_wr;
  logic               w_wr_count;
  logic               w_wr_compare;
  logic               w_wrap;
  logic [31:0]        w_count_inc;
  logic               w_match;
  logic               w_badv_load;
  logic [31:0]        w_sr;
  logic [31:0]        w_cause;

  assign w_pend       = {r_ti, HWInt};
  assign w_req_int    = (|(w_pend & r_im)) & r_ie & ~r_exl;
  assign w_req_exc    = (ExcCode_in != 5'd0) & ~r_exl;
  assign w_req        = w_req_int | w_req_exc;

  // An mtc0 that lands on the same edge as a taken request is discarded.
  assign w_wr         = en & ~w_req;
  assign w_wr_count   = w_wr & (CP0_Addr == 5'd9);
  assign w_wr_compare = w_wr & (CP0_Addr == 5'd11);

  assign w_wrap       = (r_presc == PRESC_MAX);
  assign w_count_inc  = r_count + 32'd1;
  assign w_match      = w_wrap & (w_count_inc == r_compare);

  // Address-error codes capture the faulting address, but only when no interrupt preempts.
  assign w_badv_load  = ~w_req_int & ((ExcCode_in == 5'd4) | (ExcCode_in == 5'd5));

  assign Req          = w_req;
  assign EPC_out      = r_epc;
  assign Timer_irq    = r_ti;

  // Prescaler, Count, Compare and sticky TI; runs regardless of EXL/Req.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc   <= '0;
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= CP0_in;
        r_presc <= '0;
      end else if (w_wrap) begin
        r_count <= w_count_inc;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (w_wr_compare) begin
        r_compare <= CP0_in;
      end else begin
        r_compare <= r_compare;
      end
      // A Compare write beats a coincident match.
      if (w_wr_compare) begin
        r_ti <= 1'b0;
      end else if (w_match && !w_wr_count) begin
        r_ti <= 1'b1;
      end else begin
        r_ti <= r_ti;
      end
    end
  end

  // Exception entry, mtc0 to SR/EPC and eret, in that priority order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_badvaddr <= 32'd0;
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_epc      <= 32'd0;
      r_bd       <= 1'b0;
      r_exccode  <= 5'd0;
      r_ip_hw    <= '0;
    end else begin
      r_ip_hw <= HWInt;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_epc     <= BD_in ? (VPC - 32'd4) : VPC;
        r_bd      <= BD_in;
        r_exccode <= w_req_int ? 5'd0 : ExcCode_in;
        if (w_badv_load) begin
          r_badvaddr <= BadVAddr_in;
        end else begin
          r_badvaddr <= r_badvaddr;
        end
      end else if (en) begin
        case (CP0_Addr)
          5'd12: begin
            r_im  <= CP0_in[10 +: NUM_HWINT+1];
            r_exl <= CP0_in[1];
            r_ie  <= CP0_in[0];
          end
          5'd14:   r_epc <= CP0_in;
          default: r_epc <= r_epc;
        endcase
      end else if (EXL_clr) begin
        r_exl <= 1'b0;
      end else begin
        r_exl <= r_exl;
      end
    end
  end

  // Assemble SR and Cause read images from the stored fields.
  always_comb begin
    w_sr           = 32'd0;
    w_sr[10 +: NUM_HWINT+1] = r_im;
    w_sr[1]        = r_exl;
    w_sr[0]        = r_ie;
    w_cause        = 32'd0;
    w_cause[31]    = r_bd;
    w_cause[30]    = r_ti;
    w_cause[10 +: NUM_HWINT] = r_ip_hw;
    w_cause[TB]    = r_ti;
    w_cause[6:2]   = r_exccode;
  end

  // Combinational register readback selected by CP0_Addr.
  always_comb begin
    case (CP0_Addr)
      5'd8:    CP0_out = r_badvaddr;
      5'd9:    CP0_out = r_count;
      5'd11:   CP0_out = r_compare;
      5'd12:   CP0_out = w_sr;
      5'd13:   CP0_out = w_cause;
      5'd14:   CP0_out = r_epc;
      5'd15:   CP0_out = PRID;
      default: CP0_out = 32'd0;
    endcase
  end

endmodule

// File: doc/cp0_timer_unit.md
Name: cp0_timer_unit

Overview:
- Next-generation coprocessor-0 for the P7/P8 pipeline: SR/Cause/EPC exception control, plus a BadVAddr register and a built-in Count/Compare timer.
- Hardware interrupt line count is a parameter; the timer drives the top IP bit.
- Sits beside the M stage. The M stage supplies the victim PC, branch-delay flag, ExcCode, faulting address and mtc0 data. Req flushes the pipeline and redirects fetch to the handler.

Parameters:
- NUM_HWINT, 5, number of external interrupt lines, legal 1..5; occupies IP/IM bits [10+NUM_HWINT-1:10]; timer uses bit 10+NUM_HWINT
- COUNT_DIV, 2, clk cycles per Count increment, legal 1..256
- PRID, 32'h0000_7C07, constant value returned for register 15

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  mtc0 write enable
- CP0_Addr  in  5  register select for read and write
- CP0_in  in  32  mtc0 write data
- VPC  in  32  PC of the M-stage instruction
- BD_in  in  1  M-stage instruction is in a delay slot
- ExcCode_in  in  5  pending exception code, 0 = none
- BadVAddr_in  in  32  faulting address for AdEL/AdES
- HWInt  in  NUM_HWINT  external interrupt levels
- EXL_clr  in  1  eret retiring
- CP0_out  out  32  read data, combinational on CP0_Addr
- EPC_out  out  32  current EPC
- Req  out  1  take exception/interrupt this cycle
- Timer_irq  out  1  Cause.TI

Behaviour:
- Reset: every register = 0, prescaler = 0. All outputs 0, except CP0_out, which reflects the selected register (PRID if Addr = 15).
- Register map:
  - 8 BadVAddr: read-only
  - 9 Count: R/W
  - 11 Compare: R/W
  - 12 SR: R/W, bits IM, EXL(1), IE(0); other bits read 0
  - 13 Cause: read-only
  - 14 EPC: R/W
  - 15 PRId: constant
  - Any other address reads 0; writes to it are ignored.
- Cause layout:
  - BD = bit 31, TI = bit 30
  - IP[10+NUM_HWINT:10], where the top bit is TI
  - ExcCode = bits 6:2
- Every non-reset cycle: Cause.IP[hw lines] <= HWInt. Cause.IP[timer bit] mirrors TI.
- Pending vector P = {TI, HWInt}.
  - Req_int = |(P & SR.IM) & IE & !EXL
  - Req_exc = (ExcCode_in != 0) & !EXL
  - Req = Req_int | Req_exc, combinational.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1. On wrap, Count <= Count+1, mod 2^32 (0xFFFFFFFF -> 0).
  - If the new Count == Compare, TI <= 1. TI is sticky.
  - mtc0 Compare: writes Compare and clears TI the same edge.
  - mtc0 Count: loads CP0_in, resets prescaler, suppresses that cycle's increment and match.
  - Count runs regardless of EXL/Req.
- On Req (edge):
  - EXL <= 1
  - EPC <= BD_in ? VPC-4 : VPC
  - Cause.BD <= BD_in
  - ExcCode <= Req_int ? 0 : ExcCode_in (interrupt wins over a simultaneous exception)
  - BadVAddr <= BadVAddr_in only when the exception is taken with ExcCode 4 or 5 and no interrupt.
- Priority on one edge: Req > mtc0 (en) > EXL_clr.
  - An mtc0 coinciding with Req is dropped. This includes Count/Compare writes and the TI clear.
  - An EXL_clr coinciding with en is ignored.
- Timer increment/match is independent of that priority: it still occurs on a Req edge.
- Simultaneous match and Compare write: write wins, TI = 0.
- EXL = 1 masks both interrupts and exceptions. Cause.IP and TI keep updating.
- Reset mid-operation: all state cleared on that edge; Req drops the next cycle.

Test Plan:
- Reset, then read 8/9/11/12/13/14 -> all 0. Read 15 -> 32'h0000_7C07. Read 3 -> 0. Req=0.
- COUNT_DIV=2, write Compare=3, SR=32'h0000_8001 -> Count=3 after 6 cycles. Next cycle TI=1, Cause[15]=1, Req=1. Edge: EPC=VPC, ExcCode=0, EXL=1. Write Compare=3 -> TI=0.
- ExcCode_in=4, BadVAddr_in=32'h0000_3001, BD_in=1, VPC=32'h0000_3010 -> Req=1. EPC=32'h0000_300C, BD=1, ExcCode=4, BadVAddr=32'h0000_3001.
- HWInt[2]=1 with SR=32'h0000_1001 and ExcCode_in=12 the same cycle -> ExcCode=0, BadVAddr unchanged. Repeat with EXL=1 -> Req=0 while Cause[12]=1.
- en=1 to SR with Req=1 -> SR write dropped, EXL=1. en=1 with EXL_clr=1 -> write applied, EXL=CP0_in[1].
- Count=32'hFFFF_FFFF, Compare=0 -> wraps to 0, TI=1. Write Count=5 on a wrap cycle -> Count=5, no increment.
